// File: rtl/bp_be_regfile_wb_arbiter_pkg.sv
// Shared types for the regfile writeback arbiter.
// Holds the arbiter FSM state encoding.
package bp_be_regfile_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        e_normal,
        e_stall,
        e_bubble
    } bp_be_wb_arb_state_e;

endpackage

// File: rtl/bp_be_regfile_wb_arbiter_rr.sv
// Round-robin grant for late writeback sources.
// The pointer moves past the granted way only when the grant is taken.
module bp_be_regfile_wb_arbiter_rr #(
    parameter int ways_p = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ways_p-1:0] reqs_i,
    input  logic              en_i,
    input  logic              yumi_i,
    output logic [ways_p-1:0] grants_o
);

    localparam int ptr_w = (ways_p > 1) ? $clog2(ways_p) : 1;

    logic [ptr_w-1:0] ptr_q, ptr_n;
    logic             found;
    int               idx;

    always_comb begin
        grants_o = '0;
        ptr_n    = ptr_q;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < ways_p; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= ways_p) idx = idx - ways_p;
            if (en_i && !found && reqs_i[idx]) begin
                grants_o[idx] = 1'b1;
                found         = 1'b1;
                ptr_n = (idx == ways_p - 1) ? '0 : ptr_w'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) ptr_q <= '0;
        else if (yumi_i) ptr_q <= ptr_n;
    end

endmodule

// File: rtl/bp_be_regfile_wb_arbiter.sv
// Shares one regfile write port between the pipe writeback and late sources.
// Pipe has absolute priority; a starvation FSM asks the pipe for a bubble.
module bp_be_regfile_wb_arbiter
    import bp_be_regfile_wb_arbiter_pkg::*;
#(
    parameter int data_width_p       = 64,
    parameter int reg_addr_width_p   = 5,
    parameter int late_ports_p       = 2,
    parameter int starve_limit_p     = 8,
    parameter bit zero_reg_discard_p = 1'b1
) (
    input  logic                                             clk_i,
    input  logic                                             reset_i,
    input  logic                                             pipe_v_i,
    input  logic [reg_addr_width_p-1:0]                      pipe_addr_i,
    input  logic [data_width_p-1:0]                          pipe_data_i,
    input  logic [late_ports_p-1:0]                          late_v_i,
    input  logic [late_ports_p-1:0][reg_addr_width_p-1:0]    late_addr_i,
    input  logic [late_ports_p-1:0][data_width_p-1:0]        late_data_i,
    output logic [late_ports_p-1:0]                          late_ready_o,
    output logic                                             stall_req_o,
    output logic                                             rd_w_v_o,
    output logic [reg_addr_width_p-1:0]                      rd_addr_o,
    output logic [data_width_p-1:0]                          rd_data_o
);

    typedef struct packed {
        logic [reg_addr_width_p-1:0] rd_addr;
        logic [data_width_p-1:0]     rd_data;
    } bp_be_wb_pkt_s;

    localparam int cnt_w = $clog2(starve_limit_p + 1);
    localparam logic [cnt_w-1:0] limit    = cnt_w'(starve_limit_p);
    localparam logic [cnt_w-1:0] limit_m1 = cnt_w'(starve_limit_p - 1);

    bp_be_wb_arb_state_e state_q, state_n;
    logic [cnt_w-1:0]    cnt_q, cnt_n;
    logic [late_ports_p-1:0] grant;
    logic          late_hs, blocked, accept, drop, wv_q;
    bp_be_wb_pkt_s late_pkt, sel_pkt, pkt_q;

    bp_be_regfile_wb_arbiter_rr #(.ways_p(late_ports_p)) rr (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .reqs_i   (late_v_i),
        .en_i     (!pipe_v_i && !reset_i),
        .yumi_i   (late_hs),
        .grants_o (grant)
    );

    assign late_ready_o = grant;
    assign late_hs      = |(late_v_i & grant);
    assign blocked      = (|late_v_i) && !late_hs;

    always_comb begin
        late_pkt = '0;
        for (int i = 0; i < late_ports_p; i++) begin
            if (grant[i]) late_pkt = late_pkt | {late_addr_i[i], late_data_i[i]};
        end
        sel_pkt = pipe_v_i ? {pipe_addr_i, pipe_data_i} : late_pkt;
        accept  = pipe_v_i || late_hs;
        drop    = zero_reg_discard_p && (sel_pkt.rd_addr == '0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) wv_q <= 1'b0;
        else wv_q <= accept && !drop;
    end

    always_ff @(posedge clk_i) begin
        if (accept) pkt_q <= sel_pkt;
    end

    assign rd_w_v_o  = wv_q;
    assign rd_addr_o = pkt_q.rd_addr;
    assign rd_data_o = pkt_q.rd_data;

    // Counter saturates, so a source that withdrew and returns stalls at once.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        if (late_hs) cnt_n = '0;
        else if (blocked && cnt_q != limit) cnt_n = cnt_q + cnt_w'(1);
        unique case (state_q)
            e_normal: if (blocked && cnt_q >= limit_m1) state_n = e_stall;
            e_stall:  state_n = blocked ? e_bubble : e_normal;
            e_bubble: state_n = e_normal;
            default:  state_n = e_normal;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_normal;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    assign stall_req_o = (state_q == e_stall);

`ifndef SYNTHESIS
    a_bubble_no_pipe: assert property (
        @(posedge clk_i) disable iff (reset_i)
        (state_q == e_bubble) |-> !pipe_v_i);

    for (genvar i = 0; i < late_ports_p; i++) begin : g_hold
        a_late_hold: assert property (
            @(posedge clk_i) disable iff (reset_i)
            (late_v_i[i] && !late_ready_o[i]) ##1 late_v_i[i]
            |-> $stable(late_addr_i[i]) && $stable(late_data_i[i]));
    end
`endif

endmodule
